// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run controller for core simulation.
// Sequences the core reset, counts run cycles, and ends the run on a tohost
// store, a PC self-loop hang on any monitored hart, or a cycle timeout.
// Final status, cycle count and PCs are latched for the bench to print.
module sim_run_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              NUM_HARTS    = 1,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 800,
  parameter int              STALL_LIMIT  = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 'h0000_1000,
  parameter int              CNT_W        = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              core_rst,
  input  logic [NUM_HARTS*XLEN-1:0]         pc,
  input  logic                              mem_we,
  input  logic [XLEN-1:0]                   mem_addr,
  input  logic [XLEN-1:0]                   mem_wdata,
  output logic                              running,
  output logic                              done,
  output logic [1:0]                        status,
  output logic [XLEN-2:0]                   fail_code,
  output logic [$clog2(NUM_HARTS):0]        hang_hart,
  output logic [CNT_W-1:0]                  cycle_count,
  output logic [NUM_HARTS*XLEN-1:0]         final_pc
);

  localparam int HW = $clog2(NUM_HARTS) + 1;
  localparam int SW = $clog2(STALL_LIMIT) + 1;
  localparam int RW = $clog2(RESET_CYCLES + 1) + 1;

  localparam logic [1:0] ST_PASS    = 2'd0;
  localparam logic [1:0] ST_FAIL    = 2'd1;
  localparam logic [1:0] ST_HANG    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [RW-1:0]             rcnt_reg;
  logic [NUM_HARTS*XLEN-1:0] prev_pc_reg;
  logic                      cmp_valid_reg;

  logic [1:0]                status_reg;
  logic [XLEN-2:0]           fail_code_reg;
  logic [HW-1:0]             hang_hart_reg;
  logic [CNT_W-1:0]          cycle_count_reg;
  logic [NUM_HARTS*XLEN-1:0] final_pc_reg;

  logic                      start_accept;
  logic                      reset_last;
  logic                      run_entry;
  logic                      in_run;
  logic                      tohost_hit;
  logic                      hang_any;
  logic                      timeout_hit;
  logic                      terminate;
  logic [CNT_W-1:0]          count_inc;
  logic [NUM_HARTS-1:0]      pc_same;
  logic [NUM_HARTS-1:0]      stall_hit;
  logic [HW-1:0]             hang_idx;
  logic [1:0]                status_next;

  // Run-control decode shared by the FSM and the datapath.
  assign in_run       = (state_reg == S_RUN);
  assign start_accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign reset_last   = (state_reg == S_RESET) && (rcnt_reg == RW'(RESET_CYCLES - 1));
  assign run_entry    = reset_last;

  assign tohost_hit  = in_run && mem_we && (mem_addr == TOHOST_ADDR);
  assign hang_any    = in_run && (|stall_hit);
  assign timeout_hit = in_run && (cycle_count_reg == CNT_W'(MAX_CYCLES - 1));
  assign terminate   = tohost_hit || hang_any || timeout_hit;

  // Saturate instead of wrapping so a pathological run never reports a small count.
  assign count_inc = (cycle_count_reg == {CNT_W{1'b1}}) ? cycle_count_reg
                                                        : cycle_count_reg + 1'b1;

  // Per-hart stall tracking: a hang fires on the edge where the stall count
  // would reach STALL_LIMIT-1, i.e. after STALL_LIMIT cycles on the same PC.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
      logic [SW-1:0] stall_reg;

      assign pc_same[gi]   = cmp_valid_reg &&
                             (pc[gi*XLEN +: XLEN] == prev_pc_reg[gi*XLEN +: XLEN]);
      assign stall_hit[gi] = pc_same[gi] && (stall_reg == SW'(STALL_LIMIT - 2));

      // Count consecutive unchanged-PC RUN cycles for this hart.
      always_ff @(posedge clk) begin
        if (!rst) begin
          stall_reg <= '0;
        end else if (run_entry) begin
          stall_reg <= '0;
        end else if (in_run) begin
          stall_reg <= pc_same[gi] ? stall_reg + 1'b1 : '0;
        end
      end
    end
  endgenerate

  // Lowest-index stalled hart wins; scanning downward lets low indices overwrite.
  always_comb begin
    hang_idx = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (stall_hit[h]) hang_idx = HW'(h);
    end
  end

  // Terminating status with tohost > hang > timeout priority.
  always_comb begin
    status_next = ST_TIMEOUT;
    if (tohost_hit) begin
      status_next = (mem_wdata == XLEN'(1)) ? ST_PASS : ST_FAIL;
    end else if (hang_any) begin
      status_next = ST_HANG;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // FSM next-state and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    core_rst   = 1'b1;
    running    = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_RESET;
      end
      S_RESET: begin
        if (reset_last) state_next = S_RUN;
      end
      S_RUN: begin
        core_rst = 1'b0;
        running  = 1'b1;
        if (terminate) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_RESET;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Reset-phase counter: cleared when a run is launched, counts through RESET.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt_reg <= '0;
    end else if (start_accept) begin
      rcnt_reg <= '0;
    end else if ((state_reg == S_RESET) && !reset_last) begin
      rcnt_reg <= rcnt_reg + 1'b1;
    end
  end

  // Previous-cycle PCs; the compare is armed only after the first RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_pc_reg   <= '0;
      cmp_valid_reg <= 1'b0;
    end else if (run_entry) begin
      cmp_valid_reg <= 1'b0;
    end else if (in_run) begin
      prev_pc_reg   <= pc;
      cmp_valid_reg <= 1'b1;
    end
  end

  // Result registers: cleared on launch, counted in RUN, latched on termination.
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_reg      <= ST_PASS;
      fail_code_reg   <= '0;
      hang_hart_reg   <= '0;
      cycle_count_reg <= '0;
      final_pc_reg    <= '0;
    end else if (start_accept) begin
      status_reg      <= ST_PASS;
      fail_code_reg   <= '0;
      hang_hart_reg   <= '0;
      cycle_count_reg <= '0;
      final_pc_reg    <= '0;
    end else if (run_entry) begin
      cycle_count_reg <= '0;
    end else if (in_run) begin
      cycle_count_reg <= count_inc;
      if (terminate) begin
        final_pc_reg <= pc;
        status_reg   <= status_next;
        if (status_next == ST_FAIL) fail_code_reg <= mem_wdata[XLEN-1:1];
        if (status_next == ST_HANG) hang_hart_reg <= hang_idx;
      end
    end
  end

  assign status      = status_reg;
  assign fail_code   = fail_code_reg;
  assign hang_hart   = hang_hart_reg;
  assign cycle_count = cycle_count_reg;
  assign final_pc    = final_pc_reg;

endmodule
